// File: rtl/io_port_bank_pkg.sv
// Shared constants for the memory-mapped I/O port bank: default bus width,
// default window base and the register offset encoding.
package io_pkg;

    localparam int unsigned     IO_DATA_W    = 22;
    localparam logic [21:0]     IO_BASE_ADDR = 22'h3F_FFF0;

    typedef enum logic [1:0] {
        OFS_STATE = 2'd0,
        OFS_EDGE  = 2'd1,
        OFS_OUT   = 2'd2,
        OFS_TGL   = 2'd3
    } reg_ofs_e;

endpackage

// File: rtl/io_port_bank_if.sv
// CPU data-bus view of the I/O port bank: address/write strobe from the CPU,
// window hit and combinational read data back.
interface io_port_bank_if #(
    parameter int unsigned DATA_W = 22
);
    logic [DATA_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              sel;
    logic [DATA_W-1:0] rdata;

    modport master (output adr, output wdata, output we, input sel, input rdata);
    modport slave  (input adr, input wdata, input we, output sel, output rdata);
endinterface

// File: rtl/io_port_bank_debounce.sv
// One button channel: 2-flop synchroniser on the inverted raw input, then an
// optional debouncer (IO_DEBOUNCE_EN) producing the stable level and a rise pulse.
module io_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic lvl,
    output logic rise
);
    logic sync1;
    logic sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= ~btn_n;
            sync2 <= sync1;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             accept;

    // rise is taken from the accept condition so the edge flag sets on the
    // same clock edge that lvl changes.
    assign accept = (sync2 != lvl) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise   = accept & sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else if (sync2 == lvl) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
            lvl <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign lvl  = sync2;
    assign rise = sync1 & ~sync2;
`endif

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped button/output register bank for the CPU data bus.
// Debouncing is built only when IO_DEBOUNCE_EN is defined.
module io_port_bank
    import io_pkg::*;
#(
    parameter int unsigned       DATA_W          = IO_DATA_W,
    parameter int unsigned       N_IN            = 4,
    parameter int unsigned       N_OUT           = 4,
    parameter logic [DATA_W-1:0] BASE_ADDR       = DATA_W'(IO_BASE_ADDR),
    parameter int unsigned       DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    io_port_bank_if.slave    bus,
    input  logic [N_IN-1:0]  btn_n,
    output logic [N_OUT-1:0] out_port
);
    logic [DATA_W-1:0] ofs_full;
    reg_ofs_e          ofs;
    logic              wr_en;
    logic [N_IN-1:0]   lvl;
    logic [N_IN-1:0]   rise;
    logic [N_IN-1:0]   edg;
    logic [N_IN-1:0]   edg_clr;

    // Modular subtraction gives an in-window test that stays correct for any base.
    assign ofs_full = bus.adr - BASE_ADDR;
    assign bus.sel  = (ofs_full < DATA_W'(4));
    assign ofs      = reg_ofs_e'(ofs_full[1:0]);
    assign wr_en    = bus.we & bus.sel;

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .btn_n (btn_n[i]),
            .lvl   (lvl[i]),
            .rise  (rise[i])
        );
    end

    always_comb begin
        edg_clr = '0;
        if (wr_en && (ofs == OFS_EDGE)) begin
            edg_clr = bus.wdata[N_IN-1:0];
        end
    end

    // A press on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edg <= '0;
        end else begin
            edg <= (edg & ~edg_clr) | rise;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_port <= '0;
        end else if (wr_en) begin
            case (ofs)
                OFS_OUT: out_port <= bus.wdata[N_OUT-1:0];
                OFS_TGL: out_port <= out_port ^ bus.wdata[N_OUT-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (ofs)
                OFS_STATE: bus.rdata[N_IN-1:0]  = lvl;
                OFS_EDGE:  bus.rdata[N_IN-1:0]  = edg;
                OFS_OUT:   bus.rdata[N_OUT-1:0] = out_port;
                default:   ;
            endcase
        end
    end

endmodule
